// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: bus word, widest counter, channel-select width.
package counter_bank_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WIDTH = 64;

  typedef logic [WORD_W-1:0]    int32_t;
  typedef logic [MAX_WIDTH-1:0] counter_t;

  // A single-channel bank still needs a one-bit select.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Control/status bundle for the counter bank: increment, write, read and overflow signals.
interface counter_bank_if
  import counter_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
);

  // No valid/ready handshake: every strobe (inc, wr_en, ovf_clr) is acted on at the
  // posedge where it is high, and rd_data always reflects the read address of the previous edge.
  logic [CHANNELS-1:0] inc;
  logic [CHANNELS-1:0] inhibit;
  int32_t              step;
  logic                wr_en;
  logic [SEL_W-1:0]    wr_sel;
  logic                wr_hi;
  int32_t              wr_data;
  logic [SEL_W-1:0]    rd_sel;
  logic                rd_hi;
  int32_t              rd_data;
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] ovf_clr;
  logic                irq;

  modport master (
    output inc, inhibit, step, wr_en, wr_sel, wr_hi, wr_data, rd_sel, rd_hi, ovf_clr,
    input  rd_data, ovf, irq
  );

  modport slave (
    input  inc, inhibit, step, wr_en, wr_sel, wr_hi, wr_data, rd_sel, rd_hi, ovf_clr,
    output rd_data, ovf, irq
  );

endinterface

// File: rtl/counter_bank_cell.sv
// One counter channel: half-word write, step increment with wrap or saturate, sticky overflow.
module counter_bank_cell
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en_i,
  input  int32_t           step_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  int32_t           wr_data_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             ovf_o
);

  localparam int HI_W = WIDTH - 32;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic [WIDTH:0]   sum;

  // One extra bit catches the carry out of the top counter bit.
  assign sum = {1'b0, cnt_q} + {{(WIDTH-31){1'b0}}, step_i};

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]       = wr_data_i;
      if (wr_hi_i) cnt_d[WIDTH-1:32] = HI_W'(wr_data_i);
    end else if (inc_en_i) begin
      ovf_set = sum[WIDTH];
      cnt_d   = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end
    // A fresh overflow beats a clear arriving on the same edge.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent wide counters with 32-bit half-word write/read access and overflow irq.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 64,
  parameter bit SATURATE = 1'b0
) (
  input logic           clk,
  input logic           rst,
  counter_bank_if.slave bus
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  int32_t              rd_data_q, rd_data_d;
  counter_t            rd_wide;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_cell
    logic wr_hit;
    assign wr_hit = bus.wr_en && (bus.wr_sel == SEL_W'(g));

    counter_bank_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst),
      .inc_en_i  (bus.inc[g] & ~bus.inhibit[g]),
      .step_i    (bus.step),
      .wr_lo_i   (wr_hit & ~bus.wr_hi),
      .wr_hi_i   (wr_hit &  bus.wr_hi),
      .wr_data_i (bus.wr_data),
      .ovf_clr_i (bus.ovf_clr[g]),
      .cnt_o     (cnt[g]),
      .ovf_o     (ovf_q[g])
    );
  end

  // Out-of-range selects match no channel and read as zero; widening zero-pads the upper half.
  always_comb begin
    rd_data_d = '0;
    rd_wide   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_wide   = counter_t'(cnt[i]);
        rd_data_d = bus.rd_hi ? rd_wide[63:32] : rd_wide[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ovf     = ovf_q;
  assign bus.irq     = |ovf_q;

endmodule
